input_port_unit: RTL
====================

// Module: input_port_unit
// PURPOSE
//  Per-input-port stage of the mesh router, directly upstream of the per-output four-way arbiters.
//  Buffers incoming single-flit packets in a FIFO and computes the XY route of the head flit.
//  Raises a one-hot request toward the chosen output port and holds it until granted.
//  On grant, presents the head flit to the crossbar and pops it.
// PARAMETERS
//  FLIT_W   64  flit width; dest_x = flit[FLIT_W-1 -: COORD_W], dest_y = next COORD_W bits below
//  COORD_W  4   width of each mesh coordinate
//  DEPTH    4   FIFO entries; power of two, >= 2
//  MY_X     0   this router's X coordinate
//  MY_Y     0   this router's Y coordinate
// PORTS
//  clk       in   1        single clock, all state on rising edge
//  reset     in   1        synchronous, active-high
//  in_valid  in   1        upstream flit valid
//  in_flit   in   FLIT_W   upstream flit
//  in_ready  out  1        FIFO can accept; = !full (combinational from registered count)
//  out_req   out  5        one-hot request, bit order {L,W,S,E,N} = [4:0]; feeds arbiter request inputs
//  gnt       in   1        this input won the output named by out_req (from switch control)
//  out_flit  out  FLIT_W   head flit to crossbar; meaningful only while gnt && out_req != 0
//  occupancy out  $clog2(DEPTH)+1  current FIFO count
// BEHAVIOUR
//  Reset (sync, active-high): FIFO pointers/count = 0, state = IDLE, out_req = 0, in_ready = 1, occupancy = 0.
//   Reset mid-operation flushes all buffered flits; any grant in the reset cycle is ignored.
//  Push: in_valid && in_ready at edge -> flit written at wr_ptr, wr_ptr wraps at DEPTH.
//   Full: in_ready = 0; in_valid is ignored (no drop, no overwrite).
//  Route (XY, X first), computed on the head flit:
//   dest_x > MY_X -> E; dest_x < MY_X -> W;
//   else dest_y > MY_Y -> N; dest_y < MY_Y -> S; else L.
//   Unsigned compare, COORD_W bits.
//  FSM, 2 states:
//   IDLE: out_req = 0.
//    If FIFO non-empty at the edge, latch route(head) into req_reg -> REQ.
//   REQ: out_req = req_reg, held stable with head unchanged until gnt.
//    gnt = 1: pop head at that edge (rd_ptr+1, wraps), clear req_reg -> IDLE.
//  Latency:
//   Flit pushed into an empty FIFO at edge t gives out_req valid in the cycle after edge t+1.
//   Grant-to-pop is the same edge.
//   Sustained throughput is 1 flit per 2 cycles (one IDLE bubble per flit).
//  gnt while in IDLE: ignored, no pop.
//  Simultaneous push and pop: both occur and count is unchanged.
//   When full, the pop frees an entry, but in_ready only rises the next cycle.
//  Empty FIFO: stays in IDLE with out_req = 0. out_flit is don't-care (bench must not check it).
//  out_req is never multi-hot. It is zero outside REQ.
// STRUCTURE
//  Shared package noc_pkg:
//   direction index constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3, DIR_L=4;
//   flit field offset/width constants; state encoding IDLE/REQ.
//  One sub-module: sync_fifo (FLIT_W, DEPTH).
//   Ports clk, reset, push, din, pop, dout (head, combinational), full, empty, count.
//  XY route function lives in noc_pkg so output-side blocks can reuse it.
// TESTING (MY_X=1, MY_Y=1, DEPTH=4)
//  Flit dest (3,1) pushed at edge 0, gnt=0 -> out_req=5'b00010 (E) in the cycle after edge 1, held 10 cycles unchanged.
//  Heads to (0,2), (1,0), (1,1), (1,3), each granted one cycle after req -> out_req W, S, L, N in order.
//   Flits are popped in FIFO order with matching out_flit.
//  Push 5 flits with gnt=0 -> 4 accepted; in_ready=0 and occupancy=4 after the 4th.
//   5th held by upstream, accepted the cycle after the first grant.
//  gnt=1 while empty/IDLE for 3 cycles -> occupancy stays 0 and out_req stays 0.
//  Reset asserted while in REQ with 3 flits buffered -> next cycle out_req=0, occupancy=0, in_ready=1.
//   A grant in the reset cycle pops nothing.
//  Continuous push and always-gnt for 16 flits -> 1 pop per 2 cycles.
//   Output order matches input order, and pointers wrap at 4 without loss.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: direction indices, flit field layout, input-port FSM states,
// and the XY routing function used by both input- and output-side blocks.
package noc_pkg;

  localparam int NUM_DIRS = 5;
  localparam int DIR_N    = 0;
  localparam int DIR_E    = 1;
  localparam int DIR_S    = 2;
  localparam int DIR_W    = 3;
  localparam int DIR_L    = 4;

  localparam int FLIT_W_DEF  = 64;
  localparam int COORD_W_DEF = 4;

  // Destination coordinates sit at the top of the flit: dest_x first, dest_y directly below.
  function automatic int dest_x_msb(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int dest_y_msb(input int flit_w, input int coord_w);
    return flit_w - 1 - coord_w;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } ipu_state_e;

  // Dimension-ordered routing: resolve X completely before moving in Y. Inputs are zero-extended.
  function automatic logic [NUM_DIRS-1:0] xy_route(input logic [31:0] dx, input logic [31:0] dy,
                                                   input logic [31:0] mx, input logic [31:0] my);
    logic [NUM_DIRS-1:0] r;
    r = '0;
    if (dx > mx)      r[DIR_E] = 1'b1;
    else if (dx < mx) r[DIR_W] = 1'b1;
    else if (dy > my) r[DIR_N] = 1'b1;
    else if (dy < my) r[DIR_S] = 1'b1;
    else              r[DIR_L] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/input_port_unit_fifo.sv
// Synchronous FIFO with combinational head output; 0-cycle read of head, push visible next cycle.
// Push is ignored while full and pop while empty, so callers never corrupt the pointers.
module sync_fifo #(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [FLIT_W-1:0]          din,
  input  logic                       pop,
  output logic [FLIT_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer wrap is the natural rollover.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a zero count already marks every entry as stale.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: buffers flits, XY-routes the head, holds a one-hot request until granted.
// Request valid one cycle after the head arrives; pops on grant; in_ready drops only when full.
module input_port_unit
  import noc_pkg::*;
#(
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int DEPTH   = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [FLIT_W-1:0]      in_flit,
  output logic                   in_ready,
  output logic [NUM_DIRS-1:0]    out_req,
  input  logic                   gnt,
  output logic [FLIT_W-1:0]      out_flit,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int DX_MSB = dest_x_msb(FLIT_W);
  localparam int DY_MSB = dest_y_msb(FLIT_W, COORD_W);

  ipu_state_e          state_q, state_d;
  logic [NUM_DIRS-1:0] req_q, req_d;
  logic [FLIT_W-1:0]   head;
  logic                full, empty, pop;
  logic [COORD_W-1:0]  dest_x, dest_y;
  logic [NUM_DIRS-1:0] head_route;

  sync_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .din   (in_flit),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign in_ready   = !full;
  assign out_flit   = head;
  assign dest_x     = head[DX_MSB -: COORD_W];
  assign dest_y     = head[DY_MSB -: COORD_W];
  assign head_route = xy_route(32'(dest_x), 32'(dest_y), 32'(MY_X), 32'(MY_Y));

  // The route is latched rather than driven live so the request cannot glitch while the arbiter decides.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pop     = 1'b0;
    out_req = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          req_d   = head_route;
          state_d = REQ;
        end
      end
      REQ: begin
        out_req = req_q;
        if (gnt) begin
          pop     = 1'b1;
          req_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

endmodule
